// File: rtl/display_arbiter.sv
// Round-robin owner of the shared 4-digit display: grants one of three sources,
// holds the grant for HOLD_CYCLES edges and tracks the owner's value, clamped to 9999.
module display_arbiter #(
   parameter int HOLD_CYCLES = 2**24-1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  req,
   input  logic [13:0] value0,
   input  logic [13:0] value1,
   input  logic [13:0] value2,
   output logic [13:0] to_display_nr,
   output logic        overflow,
   output logic [1:0]  active_src,
   output logic [2:0]  ack,
   output logic        owned
);

   localparam int CW = $clog2(HOLD_CYCLES + 1);
   localparam logic [13:0] MAX_NR = 14'd9999;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    last_q, last_d;
   logic [13:0]   disp_q, disp_d;
   logic          ovf_q, ovf_d;
   logic [1:0]    src_q, src_d;
   logic [2:0]    ack_q, ack_d;
   logic          owned_q, owned_d;

   logic          grant;
   logic [1:0]    gidx;
   logic [13:0]   owner_val;
   logic [13:0]   grant_val;
   logic [3:0]    req_ext;

   function automatic logic [13:0] sel_value(input logic [1:0] idx, input logic [13:0] v0,
                                             input logic [13:0] v1, input logic [13:0] v2);
      case (idx)
         2'd0:    sel_value = v0;
         2'd1:    sel_value = v1;
         default: sel_value = v2;
      endcase
   endfunction

   function automatic logic [13:0] clamp(input logic [13:0] v);
      clamp = (v > MAX_NR) ? MAX_NR : v;
   endfunction

   // Scan from lowest to highest priority so the first requester after 'last' wins.
   function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
      logic [1:0] pick;
      int         t;
      pick = last;
      for (int k = 3; k >= 1; k--) begin
         t = (int'(last) + k) % 3;
         if (r[t[1:0]]) pick = t[1:0];
      end
      return pick;
   endfunction

   assign req_ext   = {1'b0, req};
   assign gidx      = rr_pick(req, last_q);
   assign owner_val = sel_value(src_q, value0, value1, value2);
   assign grant_val = sel_value(gidx, value0, value1, value2);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      disp_d  = disp_q;
      ovf_d   = ovf_q;
      src_d   = src_q;
      ack_d   = 3'b000;
      owned_d = owned_q;
      grant   = 1'b0;

      case (state_q)
         IDLE: grant = |req;
         HOLD: begin
            if (cnt_q == CW'(1)) begin
               if (|req) begin
                  grant = 1'b1;
               end else begin
                  state_d = IDLE;
                  owned_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
               if (req_ext[src_q]) begin
                  disp_d = clamp(owner_val);
                  ovf_d  = (owner_val > MAX_NR);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (grant) begin
         state_d = HOLD;
         cnt_d   = CW'(HOLD_CYCLES);
         last_d  = gidx;
         src_d   = gidx;
         ack_d   = 3'b001 << gidx;
         owned_d = 1'b1;
         disp_d  = clamp(grant_val);
         ovf_d   = (grant_val > MAX_NR);
      end
   end

   // Last pointer resets to 2 so source 0 is first in line after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= 2'd2;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
         src_q   <= 2'd0;
         ack_q   <= 3'b000;
         owned_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
         src_q   <= src_d;
         ack_q   <= ack_d;
         owned_q <= owned_d;
      end
   end

   assign to_display_nr = disp_q;
   assign overflow      = ovf_q;
   assign active_src    = src_q;
   assign ack           = ack_q;
   assign owned         = owned_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: directed scenarios then randomized traffic against a
// cycle-level model of the grant/hold/clamp rules.
module tb_display_arbiter;

   localparam int HOLD = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  req = 3'b000;
   logic [13:0] value0 = '0, value1 = '0, value2 = '0;
   logic [13:0] to_display_nr;
   logic        overflow;
   logic [1:0]  active_src;
   logic [2:0]  ack;
   logic        owned;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   bit m_owned;
   int m_rem, m_last, m_src, m_disp, m_ovf, m_ack;

   display_arbiter #(.HOLD_CYCLES(HOLD)) dut (
      .clk(clk), .reset(reset), .req(req),
      .value0(value0), .value1(value1), .value2(value2),
      .to_display_nr(to_display_nr), .overflow(overflow),
      .active_src(active_src), .ack(ack), .owned(owned)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int val_of(input int i);
      case (i)
         0:       return int'(value0);
         1:       return int'(value1);
         default: return int'(value2);
      endcase
   endfunction

   task automatic m_reset();
      m_owned = 0; m_rem = 0; m_last = 2; m_src = 0; m_disp = 0; m_ovf = 0; m_ack = 0;
   endtask

   task automatic m_show(input int v);
      if (v > 9999) begin m_disp = 9999; m_ovf = 1; end
      else          begin m_disp = v;    m_ovf = 0; end
   endtask

   // One clock edge of the arbiter as described behaviourally.
   task automatic m_edge();
      int g;
      m_ack = 0;
      if (!m_owned || m_rem == 1) begin
         g = -1;
         for (int k = 1; k <= 3 && g < 0; k++)
            if (req[(m_last + k) % 3]) g = (m_last + k) % 3;
         if (g >= 0) begin
            m_owned = 1; m_src = g; m_last = g; m_rem = HOLD; m_ack = 1 << g;
            m_show(val_of(g));
         end else begin
            m_owned = 0;
         end
      end else begin
         m_rem--;
         if (req[m_src]) m_show(val_of(m_src));
      end
   endtask

   task automatic check_model(input string tag);
      check_eq({tag, ".disp"},  to_display_nr, m_disp);
      check_eq({tag, ".ovf"},   overflow,      m_ovf);
      check_eq({tag, ".src"},   active_src,    m_src);
      check_eq({tag, ".ack"},   ack,           m_ack);
      check_eq({tag, ".owned"}, owned,         m_owned);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, ".disp"},  to_display_nr, 0);
      check_eq({tag, ".ovf"},   overflow,      0);
      check_eq({tag, ".src"},   active_src,    0);
      check_eq({tag, ".ack"},   ack,           0);
      check_eq({tag, ".owned"}, owned,         0);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      m_edge();
      #1;
      check_model(tag);
   endtask

   // Asserts reset between edges; outputs must clear without a clock.
   task automatic async_reset(input string tag);
      #2 reset = 1'b0;
      #1 check_reset_vals(tag);
      m_reset();
      reset = 1'b1;
   endtask

   function automatic logic [13:0] rand_val();
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
         0:       return 14'd9999;
         1:       return 14'd10000;
         2:       return 14'd16383;
         3, 4:    return 14'($urandom_range(10001, 16382));
         default: return 14'($urandom_range(0, 9998));
      endcase
   endfunction

   initial begin
      int exp_src[4] = '{0, 1, 2, 0};
      int gi;

      // reset held with all sources requesting
      m_reset();
      req = 3'b111; value0 = 14'd11; value1 = 14'd22; value2 = 14'd33;
      #2 reset = 1'b0;
      #1 check_reset_vals("rst_async");
      repeat (2) @(posedge clk);
      #1 check_reset_vals("rst_held");
      reset = 1'b1;

      // round robin from release: grants at edges 1,5,9,13
      gi = 0;
      for (int e = 1; e <= 13; e++) begin
         step("rr");
         if (e % HOLD == 1) begin
            check_eq("rr_grant_src", active_src, exp_src[gi]);
            check_eq("rr_grant_ack", ack, 1 << exp_src[gi]);
            gi++;
         end
      end

      // owner 0 tracks 777, then reset mid-hold
      req = 3'b001; value0 = 14'd777;
      step("own0");
      check_eq("own0_777", to_display_nr, 777);
      async_reset("rst_mid");
      req = 3'b100; value2 = 14'd12000;
      step("after_rst");
      check_eq("after_rst_src", active_src, 2);
      check_eq("after_rst_ack", ack, 3'b100);
      check_eq("clamp_hi_disp", to_display_nr, 9999);
      check_eq("clamp_hi_ovf", overflow, 1);
      value2 = 14'd42;
      step("clamp_lo");
      check_eq("clamp_lo_disp", to_display_nr, 42);
      check_eq("clamp_lo_ovf", overflow, 0);

      // drain to idle, then single source 1
      req = 3'b000;
      repeat (HOLD) step("drain");
      check_eq("drain_owned", owned, 0);
      req = 3'b010; value1 = 14'd1234;
      step("single");
      check_eq("single_disp", to_display_nr, 1234);
      check_eq("single_src", active_src, 1);
      check_eq("single_ack", ack, 3'b010);
      value1 = 14'd1240;
      step("track");
      check_eq("track_disp", to_display_nr, 1240);
      check_eq("track_ack", ack, 0);

      // owner releases two cycles in: frozen, then idle at expiry
      req = 3'b000; value1 = 14'd5555;
      repeat (3) step("release");
      check_eq("release_disp", to_display_nr, 1240);
      check_eq("release_owned", owned, 0);
      check_eq("release_src", active_src, 1);
      req = 3'b100; value2 = 14'd321;
      step("regrant");
      check_eq("regrant_ack", ack, 3'b100);
      check_eq("regrant_disp", to_display_nr, 321);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) req = 3'b000;
         else if ($urandom_range(0, 2) != 0) req = req;
         else req = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 0) value0 = rand_val();
         if ($urandom_range(0, 1) == 0) value1 = rand_val();
         if ($urandom_range(0, 1) == 0) value2 = rand_val();
         step("rand");
         if ($urandom_range(0, 249) == 0) async_reset("rand_rst");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Shares the single 4-digit seven-segment `display` path among three requesters in the calculator: operand A entry, operand B entry, and the result/status source. A round-robin arbiter grants the display to one source at a time and enforces a minimum hold time so the shown number cannot flicker between sources. While a source owns the display, the arbiter tracks that source's value live. It drives the 14-bit number into `display.to_display_nr`, clamped to the 4-digit decimal range.

## Interface
- `HOLD_CYCLES`, default 2**24-1: number of clock cycles a grant lasts before re-arbitration; legal range ≥1.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `req` in 3: per-source display request, bit i = source i.
- `value0` in 14: unsigned number offered by source 0.
- `value1` in 14: unsigned number offered by source 1.
- `value2` in 14: unsigned number offered by source 2.
- `to_display_nr` out 14: registered number for the display, range 0–9999.
- `overflow` out 1: registered; 1 when the shown source value exceeded 9999 and was clamped.
- `active_src` out 2: registered index of the current/last owner (0–2, never 3).
- `ack` out 3: one-cycle pulse on bit i at the edge source i is granted.
- `owned` out 1: registered; 1 while a grant is in force (state HOLD).

## Operation
- Reset (reset=0, asynchronous) forces these values, held until the first edge after release:
  - `to_display_nr`=0, `overflow`=0, `active_src`=0, `ack`=0, `owned`=0.
  - State IDLE; hold counter 0; round-robin "last" pointer = 2, so source 0 has highest priority first.
- States:
  - IDLE: no owner; display holds its last value.
  - HOLD: an owner is granted; the counter runs.
- Round-robin order: start at (last+1) mod 3 and pick the first i with `req[i]`=1.
- Grant action, at one edge:
  - `active_src`=i, `ack[i]`=1 for one cycle, `owned`=1, last=i.
  - Counter loaded with `HOLD_CYCLES`.
  - Display loaded from `value_i`.
- IDLE → HOLD: when any `req` is 1, perform the grant action at that edge. If `req`=0, stay in IDLE.
- HOLD behaviour:
  - Counter decrements by 1 each edge.
  - While `req[owner]`=1, `to_display_nr` and `overflow` update every edge from `value_owner`.
  - If the owner drops `req`, the display freezes at its last value.
  - No preemption before expiry.
- HOLD expiry, at the edge where counter==1:
  - Re-arbitrate round-robin. The owner is eligible but has lowest priority.
  - Any requester present: grant it. This includes re-granting the same owner (counter reloaded, `ack` pulses again).
  - No requester: go to IDLE with `owned`=0. `active_src` and `to_display_nr` are retained.
- Clamping:
  - Value >9999: `to_display_nr`=9999, `overflow`=1.
  - Otherwise pass through with `overflow`=0.
- Counter width: $clog2(HOLD_CYCLES+1).
- All outputs are registered; none is combinational from inputs.

## Timing
- Grant latency: `req` sampled high in IDLE at edge E → outputs reflect the grant after E. One cycle of latency, zero wait states.
- Consecutive grant edges are exactly `HOLD_CYCLES` edges apart while requests persist. With `HOLD_CYCLES`=1, arbitration happens every cycle.
- Live value tracking: a change in `value_owner` appears on `to_display_nr` one edge later.
- Simultaneous requests: resolved in a single cycle by round-robin; exactly one `ack` bit is high per cycle.
- `req` rising in the same cycle as expiry: it is included in that arbitration.
- Owner drops `req` on the expiry cycle: treated as not requesting.
- Reset asserted mid-HOLD: all outputs go to their reset values immediately, without waiting for a clock edge. No `ack` is generated. After release, arbitration restarts from source 0.

## Test plan
- Reset: hold `reset`=0 with `req`=3'b111 → `to_display_nr`=0, `ack`=0, `owned`=0, `active_src`=0. After release, source 0 is granted at the first edge.
- Single source, `HOLD_CYCLES`=4: `req[1]`=1 with `value1`=1234 → one edge later `to_display_nr`=1234, `active_src`=1, `ack`=3'b010 for one cycle. Changing `value1`=1240 → display shows 1240 one edge later.
- Round-robin, `HOLD_CYCLES`=4: `req`=3'b111 held from reset release → grants to sources 0, 1, 2, 0 at edges 1, 5, 9, 13, with one `ack` pulse each.
- Clamp: owner value 12000 → `to_display_nr`=9999, `overflow`=1. Owner value 42 → `to_display_nr`=42, `overflow`=0.
- Release and idle: owner drops `req` two cycles into HOLD, no other requests → display frozen; at expiry `owned`=0 and `active_src` is unchanged. Then `req[2]`=1 → granted at the next edge.
- Mid-operation reset: assert `reset`=0 during HOLD with `to_display_nr`=777 → all outputs 0 before the next clock edge. After release with `req`=3'b100 → source 2 is granted at the first edge.
